serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..width-1 (ceil(log2(width)), at least 1).
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder used by the serial datapath.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, registered carry.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             c_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             accept, last_bit;
  logic             bit_sum, bit_carry;

  // Subtraction is a + ~b + 1, so cout=1 means no borrow.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  full_adder_bit u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (c_reg),
    .sum  (bit_sum),
    .carry(bit_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right so the active bit is always at index 0; sum fills from the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      c_reg    <= 1'b0;
      cout_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b_in;
      c_reg   <= cin_in;
      cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      sum_reg <= {bit_sum, sum_reg[WIDTH-1:1]};
      c_reg   <= bit_carry;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_bit) begin
        cout_reg <= bit_carry;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); subtract cases when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int LIMIT = 50;

  logic             clk = 1'b0;
  logic             reset, start, cin, sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse; returns just after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles (and busy samples) from the current sample until done, bounded by LIMIT.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles = 0;
    busy_cnt = 0;
    while (!done && cycles < LIMIT) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
    // Reset wins over start on the same edge.
    start = 1'b1; a = 8'h12; b = 8'h34;
    tick();
    start = 1'b0; reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_prio_busy got %b want 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_prio_idle got %b want 0", busy); end
    $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
  endtask

  task automatic test_latency();
    int cyc, bc;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, bc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL lat_cycles got %0d want 8", cyc); end
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL lat_busy_cycles got %0d want 8", bc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_at_done got %b want 0", busy); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL lat_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL lat_cout got %b want 1", cout); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lat_done_pulse got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b1) begin n_bad++; $display("FAIL lat_hold got %h/%b want 00/1", sum, cout); end
    $display("latency: FF+01+0 -> sum=%h cout=%b cycles=%0d busy=%0d", sum, cout, cyc, bc);
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va [4] = '{8'h5A, 8'h00, 8'hFF, 8'h3C};
    logic [WIDTH-1:0] vb [4] = '{8'h25, 8'h00, 8'hFF, 8'h0F};
    logic             vc [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
    logic [WIDTH-1:0] es [4] = '{8'h80, 8'h00, 8'hFF, 8'h4B};
    logic             ec [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
    int cyc, bc;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_done(cyc, bc);
      n_cmp++; if (sum !== es[i] || cout !== ec[i] || cyc !== 8) begin
        n_bad++; $display("FAIL vec%0d got sum=%h cout=%b cyc=%0d want %h/%b/8", i, sum, cout, cyc, es[i], ec[i]);
      end
      $display("vector %0d: %h+%h+%b -> sum=%h cout=%b", i, va[i], vb[i], vc[i], sum, cout);
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bc;
    start_op(8'h5A, 8'h25, 1'b1);
    tick(); tick();
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    n_cmp++; if (cyc + 3 !== 8) begin n_bad++; $display("FAIL ign_latency got %0d want 8", cyc + 3); end
    n_cmp++; if (sum !== 8'h80 || cout !== 1'b0) begin n_bad++; $display("FAIL ign_result got %h/%b want 80/0", sum, cout); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_not_queued got busy=%b want 0", busy); end
    $display("ignore start: sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_abort();
    int seen = 0;
    start_op(8'h5A, 8'h25, 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_flags got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b0) begin n_bad++; $display("FAIL abort_result got %h/%b want 00/0", sum, cout); end
    for (int i = 0; i < 20; i++) begin
      if (done) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    $display("abort: busy=%b done=%b sum=%h later_done=%0d", busy, done, sum, seen);
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'h10; b = 8'h20; cin = 1'b0;
    wait_done(cyc, bc);
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b1 || cyc !== 8) begin
      n_bad++; $display("FAIL b2b_first got %h/%b cyc=%0d want 00/1/8", sum, cout, cyc);
    end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1/0", busy, done); end
    wait_done(cyc, bc);
    n_cmp++; if (sum !== 8'h30 || cout !== 1'b0 || cyc !== 8) begin
      n_bad++; $display("FAIL b2b_second got %h/%b cyc=%0d want 30/0/8", sum, cout, cyc);
    end
    $display("back-to-back: second sum=%h cout=%b cycles=%0d", sum, cout, cyc);
    tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int cyc, bc;
    sub = 1'b1;
    start_op(8'h10, 8'h01, 1'b0);
    wait_done(cyc, bc);
    n_cmp++; if (sum !== 8'h0F || cout !== 1'b1) begin n_bad++; $display("FAIL sub_10_01 got %h/%b want 0F/1", sum, cout); end
    $display("sub: 10-01 -> sum=%h cout=%b", sum, cout);
    tick();
    start_op(8'h01, 8'h02, 1'b1);
    wait_done(cyc, bc);
    n_cmp++; if (sum !== 8'hFF || cout !== 1'b0) begin n_bad++; $display("FAIL sub_01_02 got %h/%b want FF/0", sum, cout); end
    $display("sub: 01-02 -> sum=%h cout=%b", sum, cout);
    sub = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
